// File: rtl/mux_4_pkg.sv
// Shared constants for the mux_4 block: default data width and select encodings.
package mux_4_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned SEL_WIDTH     = 2;

  typedef logic [SEL_WIDTH-1:0] sel_t;

  localparam sel_t SEL_D0 = 2'b00;
  localparam sel_t SEL_D1 = 2'b01;
  localparam sel_t SEL_D2 = 2'b10;
  localparam sel_t SEL_D3 = 2'b11;

endpackage

// File: rtl/mux_4_sel.sv
// Purely combinational 4:1 selector; bitwise routing only, no arithmetic.
module mux_4_sel
  import mux_4_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] din_0,
  input  logic [WIDTH-1:0] din_1,
  input  logic [WIDTH-1:0] din_2,
  input  logic [WIDTH-1:0] din_3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] mux_out
);

  // Every sel code maps to an input, so the case is complete by construction.
  always_comb begin
    mux_out = din_0;
    unique case (sel)
      SEL_D0: mux_out = din_0;
      SEL_D1: mux_out = din_1;
      SEL_D2: mux_out = din_2;
      SEL_D3: mux_out = din_3;
    endcase
  end

endmodule

// File: rtl/mux_4.sv
// 4:1 mux with combinational output plus a load-enabled registered copy.
// Optional change-flag output q_chg is enabled by defining MUX_4_CHG_FLAG_EN.
module mux_4
  import mux_4_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_0,
  input  logic [WIDTH-1:0] din_1,
  input  logic [WIDTH-1:0] din_2,
  input  logic [WIDTH-1:0] din_3,
  input  logic [1:0]       sel,
  input  logic             load,
  output logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] q_out,
  output logic [1:0]       q_sel,
  output logic             q_valid
`ifdef MUX_4_CHG_FLAG_EN
  ,
  output logic             q_chg
`endif
);

  mux_4_sel #(
    .WIDTH (WIDTH)
  ) u_sel (
    .din_0   (din_0),
    .din_1   (din_1),
    .din_2   (din_2),
    .din_3   (din_3),
    .sel     (sel),
    .mux_out (mux_out)
  );

  // Capture register: reset dominates load, load=0 holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_out   <= '0;
      q_sel   <= SEL_D0;
      q_valid <= 1'b0;
    end else if (load) begin
      q_out   <= mux_out;
      q_sel   <= sel;
      q_valid <= 1'b1;
    end
  end

`ifdef MUX_4_CHG_FLAG_EN
  // One-cycle pulse following a load that altered the held value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_chg <= 1'b0;
    end else begin
      q_chg <= load && (mux_out != q_out);
    end
  end
`endif

endmodule

// File: tb/tb_mux_4.sv
// Self-checking bench for mux_4: directed scenarios followed by random traffic
// against a behavioural model (array lookup plus held capture registers).
module tb_mux_4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  din [4];
  logic [1:0]  sel;
  logic        load;
  logic [7:0]  mux_out, q_out;
  logic [1:0]  q_sel;
  logic        q_valid;
  logic [15:0] din16 [4];
  logic [15:0] mux_out16, q_out16;
  logic [1:0]  q_sel16;
  logic        q_valid16;
`ifdef MUX_4_CHG_FLAG_EN
  logic        q_chg, q_chg16;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [7:0] m_q;
  logic [1:0] m_sel;
  logic       m_valid;
  logic       m_chg;
  logic [15:0] m_q16;

  always #5 clk = ~clk;

  mux_4 dut (
    .clk     (clk),
    .reset   (reset),
    .din_0   (din[0]),
    .din_1   (din[1]),
    .din_2   (din[2]),
    .din_3   (din[3]),
    .sel     (sel),
    .load    (load),
    .mux_out (mux_out),
    .q_out   (q_out),
    .q_sel   (q_sel),
    .q_valid (q_valid)
`ifdef MUX_4_CHG_FLAG_EN
    ,
    .q_chg   (q_chg)
`endif
  );

  mux_4 #(.WIDTH(16)) dut16 (
    .clk     (clk),
    .reset   (reset),
    .din_0   (din16[0]),
    .din_1   (din16[1]),
    .din_2   (din16[2]),
    .din_3   (din16[3]),
    .sel     (sel),
    .load    (load),
    .mux_out (mux_out16),
    .q_out   (q_out16),
    .q_sel   (q_sel16),
    .q_valid (q_valid16)
`ifdef MUX_4_CHG_FLAG_EN
    ,
    .q_chg   (q_chg16)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_sel = 2'b00; m_valid = 1'b0; m_chg = 1'b0; m_q16 = '0;
  endtask

  // Advance one rising edge, update the model from the values present at it.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      m_chg = load && (din[sel] != m_q);
      if (load) begin
        m_q = din[sel]; m_sel = sel; m_valid = 1'b1; m_q16 = din16[sel];
      end
    end
    #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".q_out"},   32'(q_out),   32'(m_q));
    chk({tag, ".q_sel"},   32'(q_sel),   32'(m_sel));
    chk({tag, ".q_valid"}, 32'(q_valid), 32'(m_valid));
`ifdef MUX_4_CHG_FLAG_EN
    chk({tag, ".q_chg"},   32'(q_chg),   32'(m_chg));
`endif
  endtask

  task automatic chk_mux(input string tag);
    #1;
    chk({tag, ".mux_out"}, 32'(mux_out), 32'(din[sel]));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; sel = 2'b00;
    for (int i = 0; i < 4; i++) begin
      din[i] = '0; din16[i] = '0;
    end
    model_reset();

    // Reset state
    tick();
    chk_regs("reset");
    reset = 1'b0;

    // Basic select and one-cycle load
    din[0] = 8'd1; din[1] = 8'd2; din[2] = 8'd3; din[3] = 8'd4;
    sel = 2'b01;
    chk_mux("sel01");
    chk("sel01.value", 32'(mux_out), 32'd2);
    load = 1'b1;
    tick();
    chk_regs("load01");
    chk("load01.q_out_lit", 32'(q_out), 32'd2);

    // Repeated load of the same value
    sel = 2'b11;
    tick(); chk_regs("load11a");
    tick(); chk_regs("load11b");
    chk("load11.q_out_lit", 32'(q_out), 32'd4);

    // Hold with load low, then reload
    sel = 2'b00; load = 1'b0;
    chk_mux("sel00");
    chk("sel00.value", 32'(mux_out), 32'd1);
    tick(); chk_regs("hold_a");
    tick(); chk_regs("hold_b");
    chk("hold.q_out_lit", 32'(q_out), 32'd4);
    load = 1'b1;
    tick(); chk_regs("reload00");
    chk("reload00.q_out_lit", 32'(q_out), 32'd1);

    // Asynchronous reset mid-cycle
    sel = 2'b11;
    tick();
    load = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk_regs("async_rst");
    chk("async_rst.mux_out", 32'(mux_out), 32'd4);

    // Reset beats load
    load = 1'b1;
    tick(); chk_regs("rst_vs_load");
    reset = 1'b0;
    sel = 2'b01;
    tick(); chk_regs("post_rst_load");

    // Unselected inputs have no effect
    load = 1'b0; sel = 2'b10;
    chk_mux("sel10");
    din[0] = 8'hA5; chk("unsel_d0", 32'(mux_out), 32'd3);
    din[1] = 8'h5A; chk("unsel_d1", 32'(mux_out), 32'd3);
    din[3] = 8'hFF; chk("unsel_d3", 32'(mux_out), 32'd3);
    din[2] = 8'd9; #1;
    chk("sel_d2_change", 32'(mux_out), 32'd9);

    // Wide data path
    din16[0] = 16'h1111; din16[1] = 16'h2222; din16[2] = 16'h3333; din16[3] = 16'hBEEF;
    sel = 2'b11; load = 1'b1;
    #1;
    chk("w16.mux_out", 32'(mux_out16), 32'h0000BEEF);
    tick();
    chk("w16.q_out", 32'(q_out16), 32'h0000BEEF);
    chk("w16.q_out_model", 32'(q_out16), 32'(m_q16));
    chk_regs("w16.narrow");

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) begin
        din[i]   = 8'($urandom);
        din16[i] = 16'($urandom);
      end
      sel  = 2'($urandom_range(0, 3));
      load = ($urandom_range(0, 2) != 0);
      if (n % 3 == 0) din[sel] = m_q;
      chk_mux("rnd");
      tick();
      chk_regs("rnd");
      chk("rnd.q_out16", 32'(q_out16), 32'(m_q16));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
